// File: rtl/ram_burst_pkg.sv
// ram_burst_pkg: shared types and sizing for the RAM burst controller.
// Optional bounds check: RAM_BURST_CTRL_BOUNDS_CHECK_EN.
package ram_burst_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD
    } state_t;

    localparam int RD_FIFO_DEPTH = 4;
    localparam int CNT_W = $clog2(RD_FIFO_DEPTH + 1);
    localparam int INFL_W = 2;

endpackage

// File: rtl/ram_burst_if.sv
// ram_burst_if: command, write-stream and read-stream handshakes.
// master = command issuer, slave = ram_burst_ctrl.
interface ram_burst_if #(
    parameter int DW = 8,
    parameter int AW = 10
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len;
    logic          wdata_valid;
    logic          wdata_ready;
    logic [DW-1:0] wdata;
    logic          rdata_valid;
    logic          rdata_ready;
    logic [DW-1:0] rdata;
    logic          rdata_last;
    logic          done;
    logic          err;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wdata_valid, wdata, rdata_ready,
        input  cmd_ready, wdata_ready,
        input  rdata_valid, rdata, rdata_last,
        input  done, err
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wdata_valid, wdata, rdata_ready,
        output cmd_ready, wdata_ready,
        output rdata_valid, rdata, rdata_last,
        output done, err
    );
endinterface

// File: rtl/ram_burst_rd_fifo.sv
// ram_burst_rd_fifo: 4-entry skid FIFO for read data plus last flag.
// Pushes while full are dropped; the controller's credit logic prevents them.
module ram_burst_rd_fifo
    import ram_burst_pkg::*;
#(
    parameter int W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PW = $clog2(RD_FIFO_DEPTH);

    logic [W-1:0]  mem [RD_FIFO_DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNT_W'(RD_FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: turns commands into sequential RAM write/read bursts.
// Optional macro RAM_BURST_CTRL_BOUNDS_CHECK_EN rejects wrapping bursts.
module ram_burst_ctrl
    import ram_burst_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          reset,
    ram_burst_if.slave    bus,
    output logic          ram_wr_en,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);
    state_t              state;
    logic [AW-1:0]       addr_cnt;
    logic [AW-1:0]       beats_left;
    logic                rd_all;
    logic                iss_q;
    logic                last_q;
    logic [INFL_W-1:0]   infl;
    logic                done_wr_q;
    logic [AW-1:0]       addr_hold;
    logic [DW-1:0]       din_hold;

    logic                accept;
    logic                reject;
    logic                in_wr;
    logic                wr_hs;
    logic                pop;
    logic                issue;
    logic                credit_ok;
    logic                rd_done;
    logic [3:0]          occ_sum;
    logic [DW:0]         rd_dout;
    logic                rd_full;
    logic                rd_empty;
    logic [CNT_W-1:0]    rd_count;

    assign accept = bus.cmd_valid && bus.cmd_ready;
    assign in_wr  = (state == WR) && !reset;
    assign wr_hs  = in_wr && bus.wdata_valid;

`ifdef RAM_BURST_CTRL_BOUNDS_CHECK_EN
    logic          err_q;
    logic [AW:0]   end_addr;
    assign end_addr = {1'b0, bus.cmd_addr} + {1'b0, bus.cmd_len};
    assign reject   = accept && end_addr[AW];
    assign bus.err  = err_q;
`else
    assign reject   = 1'b0;
    assign bus.err  = 1'b0;
`endif

    assign bus.cmd_ready = (state == IDLE) && !done_wr_q && !reject_q() && !reset;
    assign bus.wdata_ready = in_wr;

    assign ram_wr_en = wr_hs;
    assign ram_addr  = (in_wr || issue) ? addr_cnt : addr_hold;
    assign ram_din   = in_wr ? bus.wdata : din_hold;

    // Reads in flight plus buffered beats must fit the FIFO before issuing.
    assign occ_sum   = 4'(rd_count) + 4'(infl) - 4'(pop);
    assign credit_ok = (occ_sum < 4'(RD_FIFO_DEPTH)) && !rd_full;
    assign issue     = (state == RD) && !rd_all && credit_ok && !reset;

    assign bus.rdata_valid = !rd_empty && !reset;
    assign bus.rdata       = rd_dout[DW-1:0];
    assign bus.rdata_last  = rd_dout[DW] && bus.rdata_valid;
    assign pop             = bus.rdata_valid && bus.rdata_ready;
    assign rd_done         = (state == RD) && pop && rd_dout[DW];
    assign bus.done        = done_wr_q || rd_done;

    function automatic logic reject_q();
`ifdef RAM_BURST_CTRL_BOUNDS_CHECK_EN
        return err_q;
`else
        return 1'b0;
`endif
    endfunction

    ram_burst_rd_fifo #(.W(DW + 1)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (iss_q),
        .din   ({last_q, ram_dout}),
        .pop   (pop),
        .dout  (rd_dout),
        .full  (rd_full),
        .empty (rd_empty),
        .count (rd_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_cnt   <= '0;
            beats_left <= '0;
            rd_all     <= 1'b0;
            iss_q      <= 1'b0;
            last_q     <= 1'b0;
            infl       <= '0;
            done_wr_q  <= 1'b0;
            addr_hold  <= '0;
            din_hold   <= '0;
`ifdef RAM_BURST_CTRL_BOUNDS_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            done_wr_q <= 1'b0;
`ifdef RAM_BURST_CTRL_BOUNDS_CHECK_EN
            err_q     <= reject;
`endif
            addr_hold <= ram_addr;
            din_hold  <= ram_din;
            iss_q     <= issue;
            last_q    <= issue && (beats_left == '0);
            infl      <= infl + INFL_W'(issue) - INFL_W'(iss_q);
            unique case (state)
                IDLE: begin
                    if (accept && !reject) begin
                        addr_cnt   <= bus.cmd_addr;
                        beats_left <= bus.cmd_len;
                        rd_all     <= 1'b0;
                        state      <= bus.cmd_write ? WR : RD;
                    end
                end
                WR: begin
                    if (wr_hs) begin
                        addr_cnt   <= addr_cnt + 1'b1;
                        beats_left <= beats_left - 1'b1;
                        if (beats_left == '0) begin
                            state     <= IDLE;
                            done_wr_q <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (issue) begin
                        addr_cnt   <= addr_cnt + 1'b1;
                        beats_left <= beats_left - 1'b1;
                        if (beats_left == '0) rd_all <= 1'b1;
                    end
                    if (rd_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb_ram_burst_ctrl: scoreboard bench with a behavioural RAM and memory model.
// Expected writes/reads are queued at stimulus time and checked by a monitor.
module tb_ram_burst_ctrl;
    localparam int DW = 8;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ram_wr_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    ram_burst_if #(.DW(DW), .AW(AW)) bus ();

    ram_burst_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .ram_wr_en (ram_wr_en),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with registered read.
    logic [DW-1:0] ram_mem [1 << AW];
    always @(posedge clk) begin
        if (reset) ram_dout <= '0;
        else begin
            if (ram_wr_en) ram_mem[ram_addr] <= ram_din;
            ram_dout <= ram_mem[ram_addr];
        end
    end

    // Reference model: what the memory should hold after each write burst.
    logic [DW-1:0] model [1 << AW];
    logic [AW+DW-1:0] wq [$];
    logic [DW:0]      rq [$];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int acc_cyc = -1;
    int done_cyc = -1;
    int rmode = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin : ready_drv
        int idx = 0;
        bus.rdata_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: bus.rdata_ready = 1'b1;
                1: bus.rdata_ready = (idx == 0);
                2: bus.rdata_ready = 1'($urandom_range(0, 1));
                default: bus.rdata_ready = 1'b0;
            endcase
            idx = (idx == 2) ? 0 : idx + 1;
        end
    end

    // Monitor: pops scoreboard queues whenever the DUT presents a transfer.
    logic        held_q = 1'b0;
    logic [DW+1:0] held_v;
    always @(negedge clk) begin
        if (reset) held_q = 1'b0;
        else begin
            if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;
            if (bus.done) done_cyc = cyc;
            if (ram_wr_en) begin
                if (wq.size() == 0) chk("spurious_wr", 1, 0);
                else begin
                    logic [AW+DW-1:0] e;
                    e = wq.pop_front();
                    chk("wr_addr", 32'(ram_addr), 32'(e[AW+DW-1:DW]));
                    chk("wr_data", 32'(ram_din), 32'(e[DW-1:0]));
                end
            end
            if (held_q)
                chk("rd_hold", 32'({bus.rdata_valid, bus.rdata_last,
                    bus.rdata}), 32'(held_v));
            if (bus.rdata_valid && bus.rdata_ready) begin
                if (rq.size() == 0) chk("spurious_rd", 1, 0);
                else begin
                    logic [DW:0] e;
                    e = rq.pop_front();
                    chk("rd_data", 32'(bus.rdata), 32'(e[DW-1:0]));
                    chk("rd_last", 32'(bus.rdata_last), 32'(e[DW]));
                    chk("rd_done", 32'(bus.done), 32'(e[DW]));
                end
            end
            held_q = bus.rdata_valid && !bus.rdata_ready;
            held_v = {bus.rdata_valid, bus.rdata_last, bus.rdata};
        end
    end

    task automatic issue_cmd(input logic w, input logic [AW-1:0] a,
                             input logic [AW-1:0] l);
        bit ok = 0;
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        while (!ok && n < 2000) begin
            @(negedge clk);
            ok = bus.cmd_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.cmd_valid = 1'b0;
        if (!ok) chk("cmd_accept_timeout", 0, 1);
    endtask

    // base < 0 selects random data, otherwise base, base+1, ...
    task automatic drive_wdata(input logic [AW-1:0] a, input int len,
                               input int gap, input int base,
                               output int ncyc);
        logic [DW-1:0] d [$];
        logic [AW-1:0] aa;
        ncyc = 0;
        for (int i = 0; i <= len; i++) begin
            aa = a + AW'(i);
            d.push_back((base < 0) ? DW'($urandom) : DW'(base + i));
            model[aa] = d[i];
            wq.push_back({aa, d[i]});
        end
        for (int i = 0; i <= len; i++) begin
            bit hs = 0;
            int n = 0;
            while ($urandom_range(0, 99) < gap) begin
                bus.wdata_valid = 1'b0;
                @(posedge clk);
                #1;
                ncyc++;
            end
            bus.wdata_valid = 1'b1;
            bus.wdata = d[i];
            while (!hs && n < 100) begin
                @(negedge clk);
                hs = bus.wdata_ready;
                @(posedge clk);
                #1;
                ncyc++;
                n++;
            end
            if (!hs) chk("wdata_timeout", 0, 1);
        end
        bus.wdata_valid = 1'b0;
        @(negedge clk);
        chk("wr_done_pulse", 32'(bus.done), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic push_reads(input logic [AW-1:0] a, input int len);
        logic [AW-1:0] aa;
        for (int i = 0; i <= len; i++) begin
            aa = a + AW'(i);
            rq.push_back({(i == len), model[aa]});
        end
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (rq.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("rd_drain_left", rq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic write_burst(input logic [AW-1:0] a, input int len,
                               input int gap, input int base);
        int nc;
        issue_cmd(1'b1, a, AW'(len));
        drive_wdata(a, len, gap, base, nc);
    endtask

    task automatic read_burst(input logic [AW-1:0] a, input int len,
                              input int m);
        rmode = m;
        issue_cmd(1'b0, a, AW'(len));
        push_reads(a, len);
        wait_drain(2000);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin : main
        int nc;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_len = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 0);
        chk("rst_wdata_ready", 32'(bus.wdata_ready), 0);
        chk("rst_rdata_valid", 32'(bus.rdata_valid), 0);
        chk("rst_rdata_last", 32'(bus.rdata_last), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_wr_en", 32'(ram_wr_en), 0);
        chk("rst_addr", 32'(ram_addr), 0);
        chk("rst_din", 32'(ram_din), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 1);
        @(posedge clk);
        #1;

        // Fill the whole memory: cmd_len = 2**AW-1.
        write_burst('0, (1 << AW) - 1, 20, -1);

        // Data 5..9 at 0..4, valid held: five beats in five cycles.
        issue_cmd(1'b1, 10'd0, 10'd4);
        drive_wdata(10'd0, 4, 0, 5, nc);
        chk("wr_cycles", 32'(nc), 5);

        // First read beat three cycles after accept, then back-to-back.
        rmode = 0;
        issue_cmd(1'b0, 10'd0, 10'd4);
        push_reads(10'd0, 4);
        @(negedge clk);
        chk("rd_lat_c1", 32'(bus.rdata_valid), 0);
        @(negedge clk);
        chk("rd_lat_c2", 32'(bus.rdata_valid), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rd_stream_valid", 32'(bus.rdata_valid), 1);
        end
        wait_drain(100);

        read_burst(10'd0, 4, 1);

        // Burst crossing the top of the address space.
`ifdef RAM_BURST_CTRL_BOUNDS_CHECK_EN
        issue_cmd(1'b1, 10'd1022, 10'd3);
        @(negedge clk);
        chk("oob_err", 32'(bus.err), 1);
        @(negedge clk);
        chk("oob_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("oob_no_wr", wq.size(), 0);
        @(posedge clk);
        #1;
`else
        issue_cmd(1'b1, 10'd1022, 10'd3);
        chk("wrap_err", 32'(bus.err), 0);
        drive_wdata(10'd1022, 3, 0, -1, nc);
        read_burst(10'd1022, 3, 0);
`endif

        // Long backpressure: issue must stop at four outstanding beats.
        rmode = 3;
        issue_cmd(1'b0, 10'd200, 10'd15);
        push_reads(10'd200, 15);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("stall_valid", 32'(bus.rdata_valid), 1);
        chk("stall_fifo_full", 32'(dut.rd_count), 4);
        rmode = 0;
        wait_drain(200);

        // Reset in the middle of a 16-beat read.
        rmode = 2;
        issue_cmd(1'b0, 10'd300, 10'd15);
        push_reads(10'd300, 15);
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(bus.rdata_valid), 0);
        chk("mid_rst_done", 32'(bus.done), 0);
        chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 0);
        @(posedge clk);
        #1;
        rq.delete();
        @(negedge clk);
        chk("mid_rst_addr", 32'(ram_addr), 0);
        chk("mid_rst_fifo", 32'(bus.rdata_valid), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        read_burst(10'd400, 7, 0);

        // Back-to-back: read held on cmd_valid while a write finishes.
        issue_cmd(1'b1, 10'd100, 10'd2);
        fork
            drive_wdata(10'd100, 2, 0, -1, nc);
            issue_cmd(1'b0, 10'd100, 10'd2);
        join
        chk("b2b_accept_cycle", 32'(acc_cyc), 32'(done_cyc + 1));
        push_reads(10'd100, 2);
        wait_drain(100);

        for (int k = 0; k < 20; k++) begin
            int len;
            logic [AW-1:0] a;
            len = $urandom_range(0, 15);
            a = AW'($urandom_range(0, 1008));
            if ($urandom_range(0, 1) == 1)
                write_burst(a, len, $urandom_range(0, 50), -1);
            else
                read_burst(a, len, $urandom_range(0, 2));
        end

        repeat (4) @(posedge clk);
        chk("wq_empty_end", wq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
